// File: rtl/uart_tx_sched.sv
// Transmit scheduler for the uart_tx serializer: round-robin arbitration of two
// byte requesters into a shared FIFO, then one-frame-at-a-time sequencing with a guard gap.
module uart_tx_sched #(
    parameter int UART_BPS   = 9600,
    parameter int CLK_FREQ   = 50_000_000,
    parameter int FIFO_DEPTH = 8
) (
    input  logic                          sys_clk,
    input  logic                          sys_rst_n,
    input  logic [7:0]                    req0_data,
    input  logic                          req0_valid,
    output logic                          req0_ready,
    input  logic [7:0]                    req1_data,
    input  logic                          req1_valid,
    output logic                          req1_ready,
    output logic [7:0]                    tx_data,
    output logic                          tx_start,
    input  logic                          tx_end,
    output logic                          busy,
    output logic                          err_timeout,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);
    // state    | meaning
    // IDLE     | waiting for a queued byte
    // LOAD     | pop FIFO head into tx_data
    // START    | one-cycle start pulse to the serializer
    // WAIT_END | waiting for end-of-frame, bounded by the timeout
    // GUARD    | let the last data bit and stop bit drain

    localparam int AW          = $clog2(FIFO_DEPTH);
    localparam int BIT_CYC     = CLK_FREQ / UART_BPS;
    localparam int GUARD_CYC   = 2 * BIT_CYC + 4;
    localparam int TIMEOUT_CYC = 12 * BIT_CYC;
    localparam int TW          = $clog2(TIMEOUT_CYC + 1);
    localparam logic [TW-1:0] TIMEOUT_LOAD = TW'(TIMEOUT_CYC - 1);
    localparam logic [TW-1:0] GUARD_LOAD   = TW'(GUARD_CYC - 1);
    localparam logic [AW:0]   FULL_LEVEL   = (AW + 1)'(FIFO_DEPTH);

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        START,
        WAIT_END,
        GUARD
    } state_t;

    state_t        state, state_nxt;
    logic [TW-1:0] timer, timer_nxt;
    logic [7:0]    mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [AW:0]   level;
    logic [7:0]    push_data;
    logic [7:0]    tx_data_q;
    logic          empty, full, room, push, pop;
    logic          grant0, grant1, last_grant1;

    assign empty = (level == '0);
    assign full  = (level == FULL_LEVEL);
    assign pop   = (state == LOAD);
    // A pop in the same cycle frees a slot, so a full FIFO can still take a byte.
    assign room  = ~full | pop;

    always_comb begin
        grant0 = 1'b0;
        grant1 = 1'b0;
        if (req0_valid && req1_valid) begin
            grant0 = last_grant1;
            grant1 = ~last_grant1;
        end else begin
            grant0 = req0_valid;
            grant1 = req1_valid;
        end
    end

    assign req0_ready = grant0 & room;
    assign req1_ready = grant1 & room;
    assign push       = req0_ready | req1_ready;
    assign push_data  = req1_ready ? req1_data : req0_data;

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            last_grant1 <= 1'b1;
        end else if (push) begin
            last_grant1 <= req1_ready;
        end
    end

    always_ff @(posedge sys_clk) begin
        if (push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   level <= level + 1'b1;
                2'b01:   level <= level - 1'b1;
                default: level <= level;
            endcase
        end
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state     <= IDLE;
            timer     <= '0;
            tx_data_q <= 8'h00;
        end else begin
            state <= state_nxt;
            timer <= timer_nxt;
            if (state == LOAD) begin
                tx_data_q <= mem[rd_ptr];
            end
        end
    end

    // Timer is a down-counter: loaded on entry, terminal count at zero.
    always_comb begin
        state_nxt   = state;
        timer_nxt   = timer;
        tx_start    = 1'b0;
        err_timeout = 1'b0;
        case (state)
            IDLE: begin
                if (!empty) begin
                    state_nxt = LOAD;
                end
            end
            LOAD: begin
                state_nxt = START;
            end
            START: begin
                tx_start  = 1'b1;
                timer_nxt = TIMEOUT_LOAD;
                state_nxt = WAIT_END;
            end
            WAIT_END: begin
                if (tx_end) begin
                    timer_nxt = GUARD_LOAD;
                    state_nxt = GUARD;
                end else if (timer == '0) begin
                    err_timeout = 1'b1;
                    timer_nxt   = GUARD_LOAD;
                    state_nxt   = GUARD;
                end else begin
                    timer_nxt = timer - 1'b1;
                end
            end
            GUARD: begin
                if (timer == '0) begin
                    state_nxt = IDLE;
                end else begin
                    timer_nxt = timer - 1'b1;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    assign tx_data    = tx_data_q;
    assign busy       = ~empty | (state != IDLE);
    assign fifo_level = level;

endmodule
